ser_tx_framer: RTL and testbench

SER_TX_FRAMER -- requirements
Module: ser_tx_framer

---
 rtl/ser_tx_framer_pkg.sv | 28 ++
 rtl/ser_tx_framer.sv | 94 +++++++++
 tb/tb_ser_tx_framer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ser_tx_framer_pkg.sv
// ser_tx_framer_pkg
// Constants shared by the serial transmit framer and the matching receiver:
// the comma and idle byte values, the number of commas sent after reset,
// and the framer state encoding. The receiver's comma detector imports the
// same package so both ends always agree on these values.
package ser_tx_framer_pkg;

  // Comma / alignment byte sent during sync.
  localparam logic [7:0] COM_DEFAULT        = 8'hBC;
  // Filler byte sent when no valid data is offered.
  localparam logic [7:0] IDLE_DEFAULT       = 8'h7C;
  // Number of comma bytes sent after reset before any data.
  localparam int         SYNC_COUNT_DEFAULT = 4;

  // Framer state: commas first, then data/idle forever until reset.
  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } framer_state_e;

  // Width of a counter that must hold the values 0..n (at least 1 bit).
  function automatic int sync_cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ser_tx_framer.sv
// ser_tx_framer
// Serialises bytes MSB first at one bit per clk_32f cycle. After reset it
// sends SYNC_COUNT comma bytes, then switches to ACTIVE where every byte slot
// carries data_in (when valid_in) or the IDLE filler.
//
// Ports
//   clk_32f   in   bit-rate clock, all state on its rising edge
//   rst       in   synchronous active-high reset
//   data_in   in   [7:0] byte offered by the upstream lane mux
//   valid_in  in   data_in holds a real byte
//   byte_req  out  combinational load strobe; data_in/valid_in are sampled
//                  at the edge that ends a cycle with byte_req=1
//   data_out  out  serial stream, straight from the shift register MSB
//   active    out  high while in ACTIVE state
module ser_tx_framer
  import ser_tx_framer_pkg::*;
#(
  parameter logic [7:0] COM        = COM_DEFAULT,
  parameter logic [7:0] IDLE       = IDLE_DEFAULT,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       byte_req,
  output logic       data_out,
  output logic       active
);

  localparam int SYNC_W = sync_cnt_width(SYNC_COUNT);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_COUNT - 1);

  logic [7:0]        shreg_q,   shreg_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  framer_state_e     state_q,   state_d;

  // The edge that finishes bit 7 of a byte is the load edge for the next one.
  logic load_edge;
  assign load_edge = (bit_cnt_q == 3'd7);

  assign data_out = shreg_q[7];
  assign active   = (state_q == ST_ACTIVE);
  assign byte_req = active && load_edge;

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    sync_cnt_d = sync_cnt_q;
    state_d    = state_q;

    if (load_edge) begin
      bit_cnt_d = 3'd0;
      case (state_q)
        ST_SYNC: begin
          shreg_d    = COM;
          sync_cnt_d = sync_cnt_q + SYNC_W'(1);
          // The load that carries the last comma also enters ACTIVE, so the
          // very next load edge already samples data_in.
          if (sync_cnt_q == SYNC_LAST) begin
            state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          shreg_d = valid_in ? data_in : IDLE;
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end else begin
      shreg_d   = {shreg_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  // bit_cnt resets to 7 so the first edge after reset is a load edge and
  // the comma goes out without an empty byte in front of it.
  always_ff @(posedge clk_32f) begin
    if (rst) begin
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 3'd7;
      sync_cnt_q <= '0;
      state_q    <= ST_SYNC;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_ser_tx_framer.sv
// tb_ser_tx_framer
// Directed and randomised stimulus against ser_tx_framer. The reference is a
// model of the serial stream computed from the number of clock edges since
// reset: byte slot k starts at edge 8k+1, the first SYNC_COUNT slots carry
// the comma, later slots carry whatever was offered at that slot's strobe
// (or the idle byte). A small deserialiser also reassembles whole bytes from
// data_out and compares them with the byte the model says was sent.
module tb_ser_tx_framer;
  import ser_tx_framer_pkg::*;

  localparam logic [7:0] COM  = COM_DEFAULT;
  localparam logic [7:0] IDLE = IDLE_DEFAULT;
  localparam int         SC   = SYNC_COUNT_DEFAULT;

  logic       clk_32f = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       byte_req;
  logic       data_out;
  logic       active;

  int checks = 0;
  int failures = 0;

  // Model state: edges since reset release and the byte of the current slot.
  int         n = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] rx_sh = 8'h00;
  int         data_bytes_rx = 0;

  ser_tx_framer dut (
    .clk_32f (clk_32f),
    .rst     (rst),
    .data_in (data_in),
    .valid_in(valid_in),
    .byte_req(byte_req),
    .data_out(data_out),
    .active  (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  // Next edge is a load edge (n % 8 == 0) of a data slot (slot index >= SC).
  function automatic bit exp_req();
    return (n % 8 == 0) && (n / 8 >= SC);
  endfunction

  function automatic logic exp_dout();
    logic [7:0] b;
    b = m_byte;
    if (n == 0) return 1'b0;
    return b[7 - ((n - 1) % 8)];
  endfunction

  function automatic logic exp_active();
    return n >= 8 * (SC - 1) + 1;
  endfunction

  // One clock cycle: check the strobe for this cycle, drive inputs, take the
  // edge, update the model, check the outputs of the new cycle.
  task automatic step(input bit v, input logic [7:0] d, input bit r = 1'b0);
    bit was_req;
    check("byte_req", {7'b0, byte_req}, {7'b0, exp_req()});
    was_req = exp_req();
    rst = r;
    valid_in = v;
    data_in = d;
    @(posedge clk_32f);
    #1;
    if (r) begin
      n = 0;
      m_byte = 8'h00;
    end else begin
      if (n % 8 == 0) begin
        if (n / 8 < SC) m_byte = COM;
        else m_byte = v ? d : IDLE;
      end
      n++;
    end
    check("data_out", {7'b0, data_out}, {7'b0, exp_dout()});
    check("active", {7'b0, active}, {7'b0, exp_active()});
    if (!r && n > 0) begin
      rx_sh = {rx_sh[6:0], data_out};
      if (n % 8 == 0) begin
        check("rx_byte", rx_sh, m_byte);
        if (n / 8 > SC && rx_sh != IDLE) data_bytes_rx++;
      end
    end
    if (was_req)
      $display("strobe edge=%0d valid=%0b data=%h", n, v, d);
    rst = 1'b0;
  endtask

  // Idle until the next strobe, then offer (v, d) at it.
  task automatic send(input bit v, input logic [7:0] d, input bit noisy = 1'b0);
    while (!exp_req()) begin
      if (noisy) step($urandom_range(0, 1), 8'hEE);
      else step(1'b0, 8'($urandom));
    end
    step(v, d);
  endtask

  initial begin
    // Hold reset through a couple of edges, then check the reset state.
    rst = 1'b1;
    @(posedge clk_32f);
    #1;
    step(1'b0, 8'h00, 1'b1);
    check("rst_data_out", {7'b0, data_out}, 8'h00);
    check("rst_active", {7'b0, active}, 8'h00);
    check("rst_byte_req", {7'b0, byte_req}, 8'h00);

    // Sync: four commas with valid_in low; active rises after edge 25.
    for (int i = 0; i < 24; i++) step(1'b0, 8'h00);
    check("active_before_25", {7'b0, active}, 8'h00);
    step(1'b0, 8'h00);
    check("active_after_25", {7'b0, active}, 8'h01);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00);
    check("first_strobe_cycle33", {7'b0, byte_req}, 8'h01);
    // A few idle bytes.
    for (int i = 0; i < 24; i++) step(1'b0, 8'h00);

    // Back-to-back data.
    send(1'b1, 8'hA5);
    send(1'b1, 8'h3C);
    send(1'b1, 8'hFF);
    // Valid gap.
    send(1'b1, 8'h01);
    send(1'b0, 8'h99);
    send(1'b1, 8'h02);
    // Noise on non-strobe cycles only; strobes offer nothing.
    for (int i = 0; i < 3; i++) send(1'b0, 8'hEE, 1'b1);

    // Reset in the middle of 0xF0: next cycle data_out=0 and sync restarts.
    send(1'b1, 8'hF0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
    step(1'b1, 8'hEE, 1'b1);
    check("midrst_data_out", {7'b0, data_out}, 8'h00);
    check("midrst_active", {7'b0, active}, 8'h00);
    // Full resync with noise driven every cycle; nothing may be sampled.
    for (int i = 0; i < 8 * SC; i++) step($urandom_range(0, 1), 8'hEE);
    send(1'b1, 8'hA5);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) step(1'b0, 8'h00, 1'b1);
      else step($urandom_range(0, 1), 8'($urandom));
    end
    // Let the last byte drain through the deserialiser.
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00);

    check("data_bytes_seen", {7'b0, data_bytes_rx > 0}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
